// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level line controller: runs START/STOP/WRITE/READ as four quarter-bit
// phases paced by the bit timer, with clock stretching and arbitration-loss handling.
module i2c_bit_ctrl #(
  parameter bit STRETCH_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] Cmd,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic       DinBit,
  output logic       DoutBit,
  output logic       Done,
  output logic       ArbLost,
  input  logic       Tick,
  output logic       TimerStart,
  output logic       TimerStop,
  output logic       Scl_o,
  output logic       Sda_o,
  input  logic       Scl_i,
  input  logic       Sda_i
);

  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  typedef enum logic [2:0] {IDLE, PA, PB, PC, PD} state_e;

  state_e     state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic       din_q, din_d;
  logic       dout_q, dout_d;
  logic       done_q, done_d;
  logic       arb_q, arb_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       ready_q, ready_d;
  logic       tstart_q, tstart_d;
  logic       stretch, tick_eff, arb_chk, lost;

  // {scl, sda} for a given command and phase; d is the data bit on the wire.
  function automatic logic [1:0] phase_lines(input logic [2:0] cmd, input state_e ph,
                                             input logic d);
    logic [1:0] l;
    l = 2'b11;
    unique case (cmd)
      CMD_START: l = (ph == PC) ? 2'b10 : (ph == PD) ? 2'b00 : 2'b11;
      CMD_STOP:  l = (ph == PA) ? 2'b00 : (ph == PD) ? 2'b11 : 2'b10;
      default:   l = {(ph == PB || ph == PC), d};
    endcase
    return l;
  endfunction

  always_comb begin
    stretch  = STRETCH_EN && (state_q == PB || state_q == PC) && scl_q && !Scl_i;
    tick_eff = Tick && !stretch;
    arb_chk  = ((cmd_q == CMD_WRITE) && din_q && (state_q == PB || state_q == PC)) ||
               ((cmd_q == CMD_STOP) && (state_q == PD));
    lost     = tick_eff && arb_chk && !Sda_i;

    // NOTE: every _d starts from its _q (or a fixed value) so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    dout_d  = dout_q;
    arb_d   = arb_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: if (CmdValid && ready_q) begin
        if (Cmd >= CMD_START && Cmd <= CMD_READ) begin
          state_d = PA;
          cmd_d   = Cmd;
          din_d   = DinBit;
          arb_d   = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      PA: if (tick_eff) state_d = PB;
      PB: if (tick_eff) begin
        state_d = PC;
        if (cmd_q == CMD_READ) dout_d = Sda_i;
      end
      PC: if (tick_eff) state_d = PD;
      PD: if (tick_eff) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (lost) begin
      state_d = IDLE;
      arb_d   = 1'b1;
      done_d  = 1'b1;
    end

    // Lines are decoded from the next phase so they change with the phase register;
    // in IDLE they hold whatever the last command left (e.g. SCL low after a bit).
    if (state_d != IDLE)
      {scl_d, sda_d} = phase_lines(cmd_d, state_d, (cmd_d == CMD_READ) ? 1'b1 : din_d);
    else if (lost)
      {scl_d, sda_d} = 2'b11;

    ready_d  = (state_d == IDLE);
    tstart_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cmd_q    <= 3'd0;
      din_q    <= 1'b0;
      dout_q   <= 1'b0;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      ready_q  <= 1'b1;
      tstart_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      arb_q    <= arb_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      ready_q  <= ready_d;
      tstart_q <= tstart_d;
    end
  end

  assign CmdReady   = ready_q;
  assign DoutBit    = dout_q;
  assign Done       = done_q;
  assign ArbLost    = arb_q;
  assign TimerStart = tstart_q;
  assign TimerStop  = stretch;
  assign Scl_o      = scl_q;
  assign Sda_o      = sda_q;

endmodule

// File: doc/i2c_bit_ctrl.md
# i2c_bit_ctrl

I2C bit-level line controller, directly downstream of `i2c_bit_timer`. It takes one bus-condition command at a time (START, STOP, WRITE bit, READ bit) and executes it as four quarter-bit phases. Each phase advances on the timer's `Out` pulse. The block drives open-drain SCL/SDA enables and controls the timer through its `Start` and `Stop` inputs. It also handles clock stretching and arbitration loss. The byte-level controller sits above it.

## Interface
- `STRETCH_EN`, default 1: 1 honours slave clock stretching; 0 ignores `Scl_i`.

- `Clk` in 1: system clock; all state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Cmd` in 3: command code. 1 START, 2 STOP, 3 WRITE, 4 READ; all other codes are NOP.
- `CmdValid` in 1: command request.
- `CmdReady` out 1: high only in IDLE.
- `DinBit` in 1: bit to send for WRITE; latched at accept.
- `DoutBit` out 1: last bit sampled by READ; holds until the next READ.
- `Done` out 1: one-cycle pulse when a command completes or aborts.
- `ArbLost` out 1: arbitration lost; sticky until the next accept.
- `Tick` in 1: quarter-bit pulse, wired to `i2c_bit_timer.Out`.
- `TimerStart` out 1: drives `i2c_bit_timer.Start`; holds the timer at its initial value.
- `TimerStop` out 1: drives `i2c_bit_timer.Stop`; freezes the timer during stretching.
- `Scl_o`, `Sda_o` out 1: 0 = pull line low, 1 = release.
- `Scl_i`, `Sda_i` in 1: sampled bus levels, already synchronised upstream.

## Operation
- FSM states: IDLE, PA, PB, PC, PD.
- IDLE → PA on accept, where accept = `CmdValid && CmdReady` with a valid code. On accept, `Cmd` and `DinBit` are latched.
- NOP accepted in IDLE: stays in IDLE, pulses `Done` the next cycle, lines unchanged.
- PA→PB→PC→PD advance on `Tick`. PD→IDLE on `Tick`, with a `Done` pulse.
- Line levels per phase (Scl/Sda, for PA, PB, PC, PD):
  - START: 1/1, 1/1, 1/0, 0/0.
  - STOP: 0/0, 1/0, 1/0, 1/1.
  - WRITE: 0/d, 1/d, 1/d, 0/d, where d = latched `DinBit`.
  - READ: same as WRITE with d = 1.
- READ: `DoutBit` <= `Sda_i` on the `Tick` that ends PB (mid SCL-high).
- `TimerStart` = 1 in IDLE and 0 in PA..PD, so each command starts from a fresh timer count.
- Clock stretching, when `STRETCH_EN` = 1:
  - Applies in PB/PC while `Scl_o` = 1 and `Scl_i` = 0.
  - `TimerStop` = 1 (combinational) for that condition.
  - `Tick` is ignored and the phase holds.
- Arbitration: in PB/PC of WRITE with d = 1, or PD of STOP, `Sda_i` = 0 when `Tick` is seen means loss. The block then:
  - sets `ArbLost` = 1,
  - releases both lines,
  - returns to IDLE and pulses `Done`.
- `Tick` while in IDLE is ignored.
- `CmdValid` while busy is ignored; no queueing.

## Timing
- Reset values: `Scl_o` = 1, `Sda_o` = 1, `CmdReady` = 1, `TimerStart` = 1, `TimerStop` = 0, `Done` = 0, `DoutBit` = 0, `ArbLost` = 0; state IDLE.
- `Rst` mid-command releases both lines immediately (asynchronous). The command is dropped and `Done` is not pulsed.
- All outputs except `TimerStop` are registered. Phase line levels appear the cycle after the state transition edge.
- Accept at edge N: state is PA and `CmdReady` = 0 after edge N; `TimerStart` falls after edge N.
- Duration: each phase lasts until the next `Tick` plus any stretch cycles. With the timer's `Ticks` = T, a full command is 4·(T+1) cycles plus stretch.
- `Done` is high for exactly one cycle after the final `Tick`. `CmdReady` = 1 in that same cycle.
- Back-to-back commands: a new accept is possible in the `Done` cycle.
- `Tick` coincident with accept is ignored; PA waits for the next `Tick`.
- `Tick` coincident with stretch is dropped, not deferred.

## Test plan
1. Reset: assert `Rst` 3 cycles during WRITE PB → `Scl_o` = `Sda_o` = 1, `CmdReady` = 1, `TimerStart` = 1 immediately; no `Done`.
2. START then STOP, timer `Ticks` = 4, bus idle high:
   - START: `Sda_o` falls while `Scl_o` = 1 at PC; `Done` 20 cycles after accept.
   - STOP: `Sda_o` rises with `Scl_o` = 1 at PD.
3. WRITE d = 0 then READ with `Sda_i` = 1 at end of PB → `Sda_o` = 0 through all WRITE phases; `DoutBit` = 1. Repeat READ with `Sda_i` = 0 → `DoutBit` = 0.
4. Stretch: WRITE, hold `Scl_i` = 0 for 12 cycles in PB → `TimerStop` = 1 for 12 cycles and command extended by 12 cycles. With `STRETCH_EN` = 0, no extension and `TimerStop` stays 0.
5. Arbitration: WRITE d = 1 with `Sda_i` = 0 in PB → `ArbLost` = 1, both lines released, `Done` pulse, `CmdReady` = 1. `ArbLost` clears on the next accept.
6. `Cmd` = 7 with `CmdValid` → `Done` next cycle, lines and `TimerStart` unchanged. A `Tick` in IDLE causes no state change.
